// File: rtl/data_cache_reader_pkg.sv
// Shared definitions for the packet data cache read side: widths,
// framing codes carried in the top bits of each data word, and the
// reader FSM state encoding.
package data_cache_reader_pkg;

    localparam int DATA_W = 134;
    localparam int ID_W   = 8;
    localparam int CNT_W  = 5;

    // Framing code lives in data[133:132].
    localparam logic [1:0] FRM_HEAD = 2'b01;
    localparam logic [1:0] FRM_MID  = 2'b11;
    localparam logic [1:0] FRM_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_PKT = 2'd2,
        ST_GUARD    = 2'd3
    } reader_state_t;

    // A head while a packet is already open, or a middle/tail with no
    // open packet, is a framing violation. Code 2'b00 is not checked.
    function automatic logic frame_violation(input logic [1:0] code,
                                             input logic       in_pkt);
        return ((code == FRM_HEAD) && in_pkt) ||
               (((code == FRM_MID) || (code == FRM_TAIL)) && !in_pkt);
    endfunction

endpackage

// File: rtl/data_cache_reader.sv
// Read-side scheduler for the packet data cache. Issues one read request
// at a time when the cache holds packets and downstream is not almost
// full, then forwards returned words and the end-of-packet descriptor
// through a one-cycle register stage.
//
// Strobe semantics: every *_wr signal is a single-cycle qualifier with no
// ready/back-pressure return; the paired data/ID/valid bus is meaningful
// only in a cycle where its strobe is high. Flow control is coarse: alf
// only gates starting a new request, never an in-flight packet.
module data_cache_reader
    import data_cache_reader_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int GUARD   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   in_reader_ID,
    input  logic [CNT_W-1:0]  in_reader_ID_count,
    output logic [ID_W-1:0]   out_reader_ID,
    output logic              out_reader_ID_wr,
    input  logic              in_reader_data_wr,
    input  logic [DATA_W-1:0] in_reader_data,
    input  logic              in_reader_valid_wr,
    input  logic              in_reader_valid,
    input  logic              in_reader_alf,
    output logic              out_reader_data_wr,
    output logic [DATA_W-1:0] out_reader_data,
    output logic              out_reader_valid_wr,
    output logic              out_reader_valid,
    output logic [31:0]       out_reader_pkt_cnt,
    output logic [15:0]       out_reader_err_cnt,
    output reader_state_t     dbg_state
);

    localparam int TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GRD_W      = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    // GUARD=0 still spends one cycle in the guard state.
    localparam int GUARD_LAST = (GUARD > 0) ? GUARD - 1 : 0;
    localparam int TMO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    reader_state_t    state, state_next;
    logic [TMO_W-1:0] wait_cnt;
    logic [GRD_W-1:0] guard_cnt;
    logic             in_pkt;
    logic             got_word;
    logic             load_id;
    logic             pkt_done;
    logic             timeout_hit;
    logic             frame_err;

    assign dbg_state = state;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the single-cycle event pulses that drive the
    // counters and the ID latch.
    always_comb begin
        state_next  = state;
        load_id     = 1'b0;
        pkt_done    = 1'b0;
        timeout_hit = 1'b0;
        frame_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if ((in_reader_ID_count != '0) && !in_reader_alf) begin
                    load_id    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT_PKT;
            end
            ST_WAIT_PKT: begin
                if (in_reader_data_wr) begin
                    frame_err = frame_violation(in_reader_data[DATA_W-1 -: 2], in_pkt);
                end
                if (in_reader_valid_wr) begin
                    pkt_done   = 1'b1;
                    state_next = ST_GUARD;
                end else if (!got_word && !in_reader_data_wr &&
                             (wait_cnt == TMO_W'(TMO_LAST))) begin
                    // A word arriving on the last cycle wins over the timeout.
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (guard_cnt == GRD_W'(GUARD_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request side: latch the head ID when leaving IDLE, strobe it one
    // cycle later while the FSM sits in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reader_ID    <= '0;
            out_reader_ID_wr <= 1'b0;
        end else begin
            if (load_id) begin
                out_reader_ID <= in_reader_ID;
            end
            out_reader_ID_wr <= (state == ST_REQ);
        end
    end

    // First-word timeout and post-packet guard counters; each clears
    // whenever the FSM is outside the state that uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            guard_cnt <= '0;
        end else begin
            if ((state == ST_WAIT_PKT) && !got_word && !in_reader_data_wr) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else if (state != ST_WAIT_PKT) begin
                wait_cnt <= '0;
            end
            if (state == ST_GUARD) begin
                guard_cnt <= guard_cnt + 1'b1;
            end else begin
                guard_cnt <= '0;
            end
        end
    end

    // Framing tracker: open/close packet on head/tail, only while a
    // request is outstanding; cleared at the start of every request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt   <= 1'b0;
            got_word <= 1'b0;
        end else if (state == ST_REQ) begin
            in_pkt   <= 1'b0;
            got_word <= 1'b0;
        end else if ((state == ST_WAIT_PKT) && in_reader_data_wr) begin
            got_word <= 1'b1;
            if (in_reader_data[DATA_W-1 -: 2] == FRM_HEAD) begin
                in_pkt <= 1'b1;
            end else if (in_reader_data[DATA_W-1 -: 2] == FRM_TAIL) begin
                in_pkt <= 1'b0;
            end
        end
    end

    // Packet counter (wraps) and error counter (saturates).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reader_pkt_cnt <= '0;
            out_reader_err_cnt <= '0;
        end else begin
            if (pkt_done) begin
                out_reader_pkt_cnt <= out_reader_pkt_cnt + 32'd1;
            end
            if ((frame_err || timeout_hit) && (out_reader_err_cnt != 16'hFFFF)) begin
                out_reader_err_cnt <= out_reader_err_cnt + 16'd1;
            end
        end
    end

    // One-cycle passthrough of words and descriptors, independent of FSM
    // state so late or post-reset words still reach downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reader_data_wr  <= 1'b0;
            out_reader_data     <= '0;
            out_reader_valid_wr <= 1'b0;
            out_reader_valid    <= 1'b0;
        end else begin
            out_reader_data_wr  <= in_reader_data_wr;
            out_reader_valid_wr <= in_reader_valid_wr;
            if (in_reader_data_wr) begin
                out_reader_data <= in_reader_data;
            end
            if (in_reader_valid_wr) begin
                out_reader_valid <= in_reader_valid;
            end
        end
    end

endmodule

// File: tb/tb_data_cache_reader.sv
// Self-checking bench for data_cache_reader: scoreboard queues for the
// forwarded words/descriptors, event monitors for request strobes, and a
// directed sequence covering request latency, backpressure, back-to-back
// spacing, timeout, framing errors and asynchronous reset mid-packet.
module tb_data_cache_reader;
    import data_cache_reader_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int GUARD   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT ----------------
    logic [ID_W-1:0]   in_reader_ID = '0;
    logic [CNT_W-1:0]  in_reader_ID_count = '0;
    logic [ID_W-1:0]   out_reader_ID;
    logic              out_reader_ID_wr;
    logic              in_reader_data_wr = 1'b0;
    logic [DATA_W-1:0] in_reader_data = '0;
    logic              in_reader_valid_wr = 1'b0;
    logic              in_reader_valid = 1'b0;
    logic              in_reader_alf = 1'b0;
    logic              out_reader_data_wr;
    logic [DATA_W-1:0] out_reader_data;
    logic              out_reader_valid_wr;
    logic              out_reader_valid;
    logic [31:0]       out_reader_pkt_cnt;
    logic [15:0]       out_reader_err_cnt;
    reader_state_t     dbg_state;

    data_cache_reader #(.TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_reader_ID        (in_reader_ID),
        .in_reader_ID_count  (in_reader_ID_count),
        .out_reader_ID       (out_reader_ID),
        .out_reader_ID_wr    (out_reader_ID_wr),
        .in_reader_data_wr   (in_reader_data_wr),
        .in_reader_data      (in_reader_data),
        .in_reader_valid_wr  (in_reader_valid_wr),
        .in_reader_valid     (in_reader_valid),
        .in_reader_alf       (in_reader_alf),
        .out_reader_data_wr  (out_reader_data_wr),
        .out_reader_data     (out_reader_data),
        .out_reader_valid_wr (out_reader_valid_wr),
        .out_reader_valid    (out_reader_valid),
        .out_reader_pkt_cnt  (out_reader_pkt_cnt),
        .out_reader_err_cnt  (out_reader_err_cnt),
        .dbg_state           (dbg_state)
    );

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    int                exp_cyc_q[$];
    logic [0:0]        exp_v_q[$];
    int                exp_v_cyc_q[$];

    int idwr_cnt      = 0;
    int last_idwr_cyc = 0;
    logic [ID_W-1:0] last_idwr_id = '0;
    int last_desc_cyc = 0;

    always @(negedge clk) begin
        if (out_reader_data_wr) begin
            if (exp_q.size() == 0) begin
                check("data_unexpected", 134'(1), 134'(0));
            end else begin
                check("data", out_reader_data, exp_q.pop_front());
                check("data_lat", 134'(cyc), 134'(exp_cyc_q.pop_front()));
            end
        end
        if (out_reader_valid_wr) begin
            last_desc_cyc = cyc;
            if (exp_v_q.size() == 0) begin
                check("valid_unexpected", 134'(1), 134'(0));
            end else begin
                check("valid", 134'(out_reader_valid), 134'(exp_v_q.pop_front()));
                check("valid_lat", 134'(cyc), 134'(exp_v_cyc_q.pop_front()));
            end
        end
        if (out_reader_ID_wr) begin
            idwr_cnt++;
            last_idwr_cyc = cyc;
            last_idwr_id  = out_reader_ID;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one cycle of word and/or descriptor, recording expectations.
    task automatic drive(input logic dwr, input logic [1:0] code,
                         input logic vwr, input logic v);
        logic [DATA_W-1:0] w;
        w = {code, 4'($urandom_range(0, 15)), $urandom(), $urandom(), $urandom(), $urandom()};
        in_reader_data_wr  = dwr;
        in_reader_data     = w;
        in_reader_valid_wr = vwr;
        in_reader_valid    = v;
        if (dwr) begin
            exp_q.push_back(w);
            exp_cyc_q.push_back(cyc + 1);
        end
        if (vwr) begin
            exp_v_q.push_back(v);
            exp_v_cyc_q.push_back(cyc + 1);
        end
        tick(1);
        in_reader_data_wr  = 1'b0;
        in_reader_valid_wr = 1'b0;
    endtask

    // Wait (bounded) for the next request strobe; returns aligned to a
    // drive slot in the cycle after the strobe.
    task automatic wait_idwr(input int budget);
        int prev;
        bit seen;
        prev = idwr_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (idwr_cnt != prev) begin
                seen = 1'b1;
                break;
            end
        end
        check("idwr_seen", 134'(seen), 134'(1));
        @(posedge clk);
        #1;
    endtask

    // head, n_mid middles, tail, then descriptor (or tail+descriptor together).
    task automatic send_pkt(input int n_mid, input logic v, input bit same_cycle);
        drive(1'b1, FRM_HEAD, 1'b0, 1'b0);
        for (int i = 0; i < n_mid; i++) drive(1'b1, FRM_MID, 1'b0, 1'b0);
        if (same_cycle) begin
            drive(1'b1, FRM_TAIL, 1'b1, v);
        end else begin
            drive(1'b1, FRM_TAIL, 1'b0, 1'b0);
            drive(1'b0, 2'b00, 1'b1, v);
        end
    endtask

    // ---------------- sequence ----------------
    int exp_pkt = 0;
    int exp_err = 0;
    int t0;
    int idle_cyc;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_id_wr", 134'(out_reader_ID_wr), 134'(0));
        check("rst_id", 134'(out_reader_ID), 134'(0));
        check("rst_pkt", 134'(out_reader_pkt_cnt), 134'(0));
        check("rst_err", 134'(out_reader_err_cnt), 134'(0));
        check("rst_dwr", 134'(out_reader_data_wr), 134'(0));
        check("rst_state", 134'(dbg_state), 134'(ST_IDLE));
        rst_n = 1'b1;
        tick(2);

        // single packet, ID 05
        in_reader_ID = 8'h05;
        in_reader_ID_count = 5'd1;
        t0 = cyc;
        wait_idwr(10);
        check("t1_req_lat", 134'(last_idwr_cyc - t0), 134'(2));
        check("t1_req_id", 134'(last_idwr_id), 134'(8'h05));
        in_reader_ID_count = 5'd0;
        send_pkt(2, 1'b1, 1'b0);
        exp_pkt++;
        tick(5);
        check("t1_pkt", 134'(out_reader_pkt_cnt), 134'(exp_pkt));
        check("t1_err", 134'(out_reader_err_cnt), 134'(exp_err));

        // backpressure before request, alf raised mid-packet
        in_reader_alf = 1'b1;
        in_reader_ID = 8'h21;
        in_reader_ID_count = 5'd3;
        t0 = idwr_cnt;
        tick(8);
        check("t2_no_req", 134'(idwr_cnt), 134'(t0));
        in_reader_alf = 1'b0;
        t0 = cyc;
        wait_idwr(10);
        check("t2_req_lat", 134'(last_idwr_cyc - t0), 134'(2));
        check("t2_req_id", 134'(last_idwr_id), 134'(8'h21));
        drive(1'b1, FRM_HEAD, 1'b0, 1'b0);
        in_reader_alf = 1'b1;
        drive(1'b1, FRM_MID, 1'b0, 1'b0);
        drive(1'b1, FRM_TAIL, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        exp_pkt++;
        tick(5);
        check("t2_pkt", 134'(out_reader_pkt_cnt), 134'(exp_pkt));
        check("t2_state", 134'(dbg_state), 134'(ST_IDLE));
        in_reader_ID_count = 5'd0;
        in_reader_alf = 1'b0;
        tick(2);

        // back-to-back: second request GUARD+2 after first descriptor
        in_reader_ID = 8'h40;
        in_reader_ID_count = 5'd2;
        wait_idwr(10);
        check("t3_req_id0", 134'(last_idwr_id), 134'(8'h40));
        in_reader_ID = 8'h41;
        send_pkt(1, 1'b1, 1'b1);
        exp_pkt++;
        wait_idwr(20);
        check("t3_b2b_gap", 134'(last_idwr_cyc - last_desc_cyc), 134'(GUARD + 2));
        check("t3_req_id1", 134'(last_idwr_id), 134'(8'h41));
        in_reader_ID_count = 5'd0;
        send_pkt(3, 1'b1, 1'b0);
        exp_pkt++;
        tick(5);
        check("t3_pkt", 134'(out_reader_pkt_cnt), 134'(exp_pkt));

        // timeout with retry
        in_reader_ID = 8'h77;
        in_reader_ID_count = 5'd1;
        wait_idwr(10);
        idle_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (dbg_state == ST_IDLE) begin
                idle_cyc = cyc;
                break;
            end
        end
        exp_err++;
        check("t4_tmo_lat", 134'(idle_cyc - last_idwr_cyc), 134'(TIMEOUT));
        check("t4_err", 134'(out_reader_err_cnt), 134'(exp_err));
        wait_idwr(10);
        check("t4_retry_lat", 134'(last_idwr_cyc - idle_cyc), 134'(2));
        in_reader_ID_count = 5'd0;
        send_pkt(0, 1'b1, 1'b0);
        exp_pkt++;
        tick(5);
        check("t4_pkt", 134'(out_reader_pkt_cnt), 134'(exp_pkt));

        // framing: head, head, tail + discard descriptor
        in_reader_ID = 8'h09;
        in_reader_ID_count = 5'd1;
        wait_idwr(10);
        in_reader_ID_count = 5'd0;
        drive(1'b1, FRM_HEAD, 1'b0, 1'b0);
        drive(1'b1, FRM_HEAD, 1'b0, 1'b0);
        drive(1'b1, FRM_TAIL, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        exp_err++;
        exp_pkt++;
        tick(5);
        check("t5_err_hh", 134'(out_reader_err_cnt), 134'(exp_err));
        check("t5_pkt", 134'(out_reader_pkt_cnt), 134'(exp_pkt));
        // middle before head
        in_reader_ID_count = 5'd1;
        wait_idwr(10);
        in_reader_ID_count = 5'd0;
        drive(1'b1, FRM_MID, 1'b0, 1'b0);
        drive(1'b1, FRM_HEAD, 1'b0, 1'b0);
        drive(1'b1, FRM_TAIL, 1'b1, 1'b1);
        exp_err++;
        exp_pkt++;
        tick(5);
        check("t5_err_mh", 134'(out_reader_err_cnt), 134'(exp_err));
        check("t5_pkt2", 134'(out_reader_pkt_cnt), 134'(exp_pkt));

        // async reset mid-packet
        in_reader_ID = 8'h33;
        in_reader_ID_count = 5'd1;
        wait_idwr(10);
        in_reader_ID_count = 5'd0;
        drive(1'b1, FRM_HEAD, 1'b0, 1'b0);
        drive(1'b1, FRM_MID, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_pkt = 0;
        exp_err = 0;
        check("t6_dwr", 134'(out_reader_data_wr), 134'(0));
        check("t6_data", out_reader_data, '0);
        check("t6_id", 134'(out_reader_ID), 134'(0));
        check("t6_pkt", 134'(out_reader_pkt_cnt), 134'(exp_pkt));
        check("t6_err", 134'(out_reader_err_cnt), 134'(exp_err));
        check("t6_state", 134'(dbg_state), 134'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        drive(1'b1, FRM_MID, 1'b0, 1'b0);
        drive(1'b1, FRM_TAIL, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        tick(5);
        check("t6_pkt_after", 134'(out_reader_pkt_cnt), 134'(exp_pkt));
        check("t6_err_after", 134'(out_reader_err_cnt), 134'(exp_err));
        check("t6_state_after", 134'(dbg_state), 134'(ST_IDLE));

        // final report
        check("exp_q_empty", 134'(exp_q.size()), 134'(0));
        check("exp_v_q_empty", 134'(exp_v_q.size()), 134'(0));
        check("idwr_total", 134'(idwr_cnt), 134'(9));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
